axi3_rd_arbiter: RTL

AXI3_RD_ARBITER -- requirements
Module: axi3_rd_arbiter

---
 rtl/axi3_rd_arbiter_pkg.sv | 42 ++++
 rtl/axi3_rd_arbiter_rr_picker.sv | 36 +++
 rtl/axi3_rd_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/axi3_rd_arbiter_pkg.sv
// ============================================================================
// axi3_rd_arbiter_pkg : shared AXI3 read-channel types and arbiter FSM states
// Revision 1.0
// ============================================================================
`default_nettype none

package axi3_rd_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] araddr;
        logic [3:0]        arlen;
        logic [2:0]        arsize;
        logic [1:0]        arburst;
        logic              arvalid;
        logic              rready;
    } axi3_rd_req_t;

    typedef struct packed {
        logic              arready;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              rlast;
        logic              rvalid;
    } axi3_rd_resp_t;

    // A single requester still needs a 1-bit index so vectors stay legal.
    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi3_rd_arbiter_rr_picker.sv
// ============================================================================
// rr_picker : first asserted request at or after the pointer, wrapping
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_picker
    import axi3_rd_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = arb_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_any
);

    // Walk the offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        int w_idx;
        w_idx   = 0;
        o_grant = '0;
        o_any   = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % N_REQ;
            if (i_req[w_idx]) begin
                o_grant = IDX_W'(w_idx);
                o_any   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi3_rd_arbiter.sv
// ============================================================================
// axi3_rd_arbiter : round-robin N:1 AXI3 read arbiter, one transaction in flight
// Revision 1.0
// ============================================================================
`default_nettype none

module axi3_rd_arbiter
    import axi3_rd_arbiter_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int BUS_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  axi3_rd_req_t         s_req  [N_REQ],
    output axi3_rd_resp_t        s_resp [N_REQ],
    output axi3_rd_req_t         m_req,
    output logic [BUS_WIDTH-1:0] m_arid,
    input  axi3_rd_resp_t        m_resp,
    input  logic [BUS_WIDTH-1:0] m_rid
);

    localparam int               IDX_W    = arb_idx_w(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] w_grant_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_pick;
    logic             w_any;
    logic [N_REQ-1:0] w_arvalid;
    axi3_rd_req_t     w_sel_req;

    always_comb begin
        w_arvalid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_arvalid[i] = s_req[i].arvalid;
        end
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .i_req   (w_arvalid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_req = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == IDX_W'(i)) begin
                w_sel_req = s_req[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = ADDR;
                    w_grant_nxt = w_pick;
                end
            end
            ADDR: begin
                if (w_sel_req.arvalid && m_resp.arready) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (m_resp.rvalid && w_sel_req.rready && m_resp.rlast) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs depend only on registered state/grant plus the granted port,
    // so arvalid never reaches m_req in the cycle it is first raised.
    always_comb begin
        m_req  = '0;
        m_arid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            s_resp[i] = '0;
        end
        case (r_state)
            ADDR: begin
                m_req.araddr  = w_sel_req.araddr;
                m_req.arlen   = w_sel_req.arlen;
                m_req.arsize  = w_sel_req.arsize;
                m_req.arburst = w_sel_req.arburst;
                m_req.arvalid = w_sel_req.arvalid;
                m_arid        = BUS_WIDTH'(r_grant);
                for (int i = 0; i < N_REQ; i++) begin
                    if (r_grant == IDX_W'(i)) begin
                        s_resp[i].arready = m_resp.arready;
                    end
                end
            end
            DATA: begin
                m_req.rready = w_sel_req.rready;
                m_arid       = BUS_WIDTH'(r_grant);
                for (int i = 0; i < N_REQ; i++) begin
                    if (r_grant == IDX_W'(i)) begin
                        s_resp[i].rdata  = m_resp.rdata;
                        s_resp[i].rresp  = m_resp.rresp;
                        s_resp[i].rlast  = m_resp.rlast;
                        s_resp[i].rvalid = m_resp.rvalid;
                    end
                end
            end
            default: ;
        endcase
    end

    // Routing trusts the grant; a mismatching RID means the interconnect misbehaved.
    a_rid_matches_grant: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == DATA && m_resp.rvalid) |-> (m_rid == BUS_WIDTH'(r_grant)));

    a_arvalid_held: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == ADDR) |-> w_sel_req.arvalid);

endmodule

`default_nettype wire
